// File: rtl/evr_dbus_encode.sv
// dbus byte-lane encoder: interleaves distributed-bus bytes with
// data-buffer frames (K28.0, payload, K28.1, inverted 16-bit sum).
module evr_dbus_encode (
  input  logic        EventClock,
  input  logic        Reset,
  input  logic [7:0]  disBus,
  input  logic        wrEn,
  input  logic [8:0]  wrAddr,
  input  logic [31:0] wrData,
  input  logic        txStart,
  input  logic [9:0]  txWords,
  output logic [7:0]  dbus,
  output logic        isK,
  output logic        dbSlot,
  output logic        txBusy,
  output logic        txDone,
  output logic        txErr
);

  typedef enum logic [2:0] {
    S_IDLE, S_PF, S_ARM, S_DATA,
    S_END, S_CSHI, S_CSLO, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  dbus_q, dbus_d;
  logic        isk_q, isk_d;
  logic        slot_q;
  logic        done_q, done_d;
  logic        err1_q, err1_d;
  logic        err_q;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] last_q, last_d;
  logic [8:0]  widx_q, widx_d;
  logic [15:0] sum_q, sum_d;
  logic [31:0] cur_q, cur_d;

  logic [31:0] mem_q [512];
  logic [31:0] rdata_q;

  logic        data_nxt;
  logic        len_ok;
  logic [31:0] word;
  logic [7:0]  pb;
  logic [7:0]  dat_b;
  logic        dat_k;

  // RAM is re-read every cycle at the word index of the frame
  always_ff @(posedge EventClock) begin
    if (wrEn) mem_q[wrAddr] <= wrData;
    rdata_q <= mem_q[widx_q];
  end

  assign data_nxt = slot_q;
  assign len_ok   = (txWords != 10'd0) &&
                    (txWords <= 10'd512);

  // byte 0 comes straight from the RAM, the rest from the snapshot
  assign word = (cnt_q[1:0] == 2'd0) ? rdata_q : cur_q;

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    pb = word[31:24];
      2'd1:    pb = word[23:16];
      2'd2:    pb = word[15:8];
      default: pb = word[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    widx_d  = widx_q;
    sum_d   = sum_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    err1_d  = 1'b0;
    dat_b   = 8'h00;
    dat_k   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (txStart) begin
          if (len_ok) begin
            state_d = S_PF;
            cnt_d   = '0;
            widx_d  = '0;
            sum_d   = '0;
            last_d  = {txWords, 2'b00} - 12'd1;
          end else begin
            err1_d = 1'b1;
          end
        end
      end
      S_PF: state_d = S_ARM;
      S_ARM: begin
        if (data_nxt) begin
          dat_b   = 8'h1C;
          dat_k   = 1'b1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (data_nxt) begin
          dat_b = pb;
          sum_d = sum_q + {8'h00, pb};
          cnt_d = cnt_q + 12'd1;
          if (cnt_q[1:0] == 2'd0) cur_d = rdata_q;
          if (cnt_q[1:0] == 2'd3) widx_d = widx_q + 9'd1;
          if (cnt_q == last_q) state_d = S_END;
        end
      end
      S_END: begin
        if (data_nxt) begin
          dat_b   = 8'h3C;
          dat_k   = 1'b1;
          state_d = S_CSHI;
        end
      end
      S_CSHI: begin
        if (data_nxt) begin
          dat_b   = ~sum_q[15:8];
          state_d = S_CSLO;
        end
      end
      S_CSLO: begin
        if (data_nxt) begin
          dat_b   = ~sum_q[7:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    dbus_d = data_nxt ? dat_b : disBus;
    isk_d  = data_nxt & dat_k;
  end

  always_ff @(posedge EventClock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      dbus_q  <= 8'h00;
      isk_q   <= 1'b0;
      slot_q  <= 1'b0;
      done_q  <= 1'b0;
      err1_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '0;
      widx_q  <= '0;
      sum_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      dbus_q  <= dbus_d;
      isk_q   <= isk_d;
      slot_q  <= ~slot_q;
      done_q  <= done_d;
      err1_q  <= err1_d;
      err_q   <= err1_q;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      widx_q  <= widx_d;
      sum_q   <= sum_d;
      cur_q   <= cur_d;
    end
  end

  assign dbus   = dbus_q;
  assign isK    = isk_q;
  assign dbSlot = slot_q;
  assign txBusy = (state_q != S_IDLE);
  assign txDone = done_q;
  assign txErr  = err_q;

endmodule

// File: tb/tb_evr_dbus_encode.sv
// Bench for evr_dbus_encode: scenario tasks against a
// frame-level reference model built from a shadow of the buffer.
module tb_evr_dbus_encode;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  disBus;
  logic        wrEn;
  logic [8:0]  wrAddr;
  logic [31:0] wrData;
  logic        txStart;
  logic [9:0]  txWords;
  logic [7:0]  dbus;
  logic        isK;
  logic        dbSlot;
  logic        txBusy;
  logic        txDone;
  logic        txErr;

  evr_dbus_encode dut (
    .EventClock (clk),
    .Reset      (rst),
    .disBus     (disBus),
    .wrEn       (wrEn),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .txStart    (txStart),
    .txWords    (txWords),
    .dbus       (dbus),
    .isK        (isK),
    .dbSlot     (dbSlot),
    .txBusy     (txBusy),
    .txDone     (txDone),
    .txErr      (txErr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dmode  = 0;

  logic [31:0] sh [512];
  logic [8:0]  exp_q [$];
  logic [8:0]  exp1_q [$];

  logic [7:0] o_db [$];
  logic [7:0] o_pd [$];
  logic       o_k  [$];
  logic       o_sl [$];
  logic       o_bz [$];
  logic       o_dn [$];
  logic       o_er [$];

  task automatic clear_trace();
    o_db.delete(); o_pd.delete(); o_k.delete();
    o_sl.delete(); o_bz.delete(); o_dn.delete();
    o_er.delete();
  endtask

  task automatic tick();
    logic [7:0] d;
    d = disBus;
    @(posedge clk);
    #1;
    o_db.push_back(dbus);
    o_pd.push_back(d);
    o_k.push_back(isK);
    o_sl.push_back(dbSlot);
    o_bz.push_back(txBusy);
    o_dn.push_back(txDone);
    o_er.push_back(txErr);
    if (dmode == 1) disBus = disBus + 8'd1;
    else if (dmode == 0) disBus = 8'($urandom);
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    wrEn = 1'b1;
    wrAddr = 9'(a);
    wrData = d;
    tick();
    wrEn = 1'b0;
    sh[a] = d;
  endtask

  // expected data-slot sequence {isK, byte} of one frame
  function automatic void build_frame(input int nw);
    int sum, bt, cs;
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h1C});
    sum = 0;
    for (int w = 0; w < nw; w++)
      for (int b = 0; b < 4; b++) begin
        bt = int'((sh[w] >> (24 - 8 * b)) & 32'hFF);
        exp_q.push_back({1'b0, 8'(bt)});
        sum = sum + bt;
      end
    exp_q.push_back({1'b1, 8'h3C});
    cs = 65535 - (sum % 65536);
    exp_q.push_back({1'b0, 8'(cs / 256)});
    exp_q.push_back({1'b0, 8'(cs % 256)});
  endfunction

  function automatic int first_data(input int from);
    for (int t = from; t < o_sl.size(); t++)
      if (o_sl[t] == 1'b0) return t;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({dbus, isK, dbSlot, txBusy, txDone, txErr} !== 13'h0) begin
      errors++;
      $display("FAIL reset_values got=%h want=0",
        {dbus, isK, dbSlot, txBusy, txDone, txErr});
    end
    rst = 1'b0;
    dmode = 2;
    disBus = 8'h5A;
    clear_trace();
    tick();
    checks++;
    if ({o_sl[0], o_db[0]} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL first_slot got=%h want=15a",
        {o_sl[0], o_db[0]});
    end
  endtask

  task automatic test_basic();
    logic [7:0] bexp [16];
    int s;
    bexp = '{8'h1C, 8'hA5, 8'h01, 8'hA5, 8'h02, 8'hA5,
             8'h03, 8'hA5, 8'h04, 8'hA5, 8'h3C, 8'hA5,
             8'hFF, 8'hA5, 8'hF5, 8'hA5};
    dmode = 2;
    disBus = 8'hA5;
    write_word(0, 32'h01020304);
    clear_trace();
    txWords = 10'd1;
    txStart = 1'b1;
    tick();
    txStart = 1'b0;
    repeat (24) tick();
    s = first_data(2);
    checks++;
    if (s < 2 || s > 3) begin
      errors++;
      $display("FAIL basic_start got=%0d want=2..3", s);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if ({o_k[s+i], o_db[s+i]} !==
            {(i == 0 || i == 10), bexp[i]}) begin
          errors++;
          $display("FAIL basic_byte%0d got=%h want=%h", i,
            {o_k[s+i], o_db[s+i]}, {(i == 0 || i == 10), bexp[i]});
        end
      end
      checks++;
      if ({o_bz[0], o_bz[s+14], o_bz[s+15], o_dn[s+15],
           o_dn[s+16]} !== 5'b11010) begin
        errors++;
        $display("FAIL basic_done got=%b want=11010",
          {o_bz[0], o_bz[s+14], o_bz[s+15], o_dn[s+15], o_dn[s+16]});
      end
    end
  endtask

  task automatic test_illegal();
    int pulses, busy, junk;
    logic [9:0] lens [2];
    lens = '{10'd0, 10'd513};
    dmode = 0;
    for (int j = 0; j < 2; j++) begin
      clear_trace();
      txWords = lens[j];
      txStart = 1'b1;
      tick();
      txStart = 1'b0;
      repeat (6) tick();
      pulses = 0; busy = 0; junk = 0;
      foreach (o_er[t]) begin
        if (o_er[t]) pulses++;
        if (o_bz[t]) busy++;
        if (!o_sl[t] && (o_db[t] != 8'h00 || o_k[t])) junk++;
      end
      checks++;
      if (o_er[1] !== 1'b1 || pulses != 1) begin
        errors++;
        $display("FAIL illegal%0d_err got=%0d pulses at1=%b want=1",
          lens[j], pulses, o_er[1]);
      end
      checks++;
      if (busy != 0 || junk != 0) begin
        errors++;
        $display("FAIL illegal%0d_idle busy=%0d nonfiller=%0d want=0",
          lens[j], busy, junk);
      end
    end
  endtask

  task automatic test_frames_dbus();
    int nw, idle, k, s, d;
    for (int it = 0; it < 6; it++) begin
      dmode = (it < 2) ? 1 : 0;
      nw = (it == 0) ? 2 : int'($urandom_range(1, 12));
      for (int w = 0; w < nw; w++) write_word(w, $urandom);
      build_frame(nw);
      clear_trace();
      idle = (it == 0) ? 20 : int'($urandom_range(0, 5));
      repeat (idle) tick();
      k = o_db.size();
      txWords = 10'(nw);
      txStart = 1'b1;
      tick();
      txStart = 1'b0;
      repeat (2 * (4 * nw + 4) + 8) tick();
      s = first_data(k + 2);
      checks++;
      if (s < k + 2 || s > k + 3) begin
        errors++;
        $display("FAIL frm%0d_start got=%0d want=2..3", it, s - k);
      end else begin
        foreach (exp_q[m]) begin
          checks++;
          if ({o_k[s+2*m], o_db[s+2*m]} !== exp_q[m]) begin
            errors++;
            $display("FAIL frm%0d_byte%0d got=%h want=%h", it, m,
              {o_k[s+2*m], o_db[s+2*m]}, exp_q[m]);
          end
        end
        d = s + 2 * exp_q.size() - 1;
        checks++;
        if ({o_bz[k], o_bz[d-1], o_bz[d], o_dn[d], o_dn[d+1]}
            !== 5'b11010) begin
          errors++;
          $display("FAIL frm%0d_done got=%b want=11010", it,
            {o_bz[k], o_bz[d-1], o_bz[d], o_dn[d], o_dn[d+1]});
        end
      end
      for (int t = 1; t < o_db.size(); t++) begin
        checks++;
        if (o_sl[t] !== ~o_sl[t-1]) begin
          errors++;
          $display("FAIL frm%0d_toggle t=%0d got=%b want=%b",
            it, t, o_sl[t], ~o_sl[t-1]);
        end
        if (o_sl[t]) begin
          checks++;
          if ({o_k[t], o_db[t]} !== {1'b0, o_pd[t]}) begin
            errors++;
            $display("FAIL frm%0d_dslot t=%0d got=%h want=%h",
              it, t, {o_k[t], o_db[t]}, {1'b0, o_pd[t]});
          end
        end else if (t < s) begin
          checks++;
          if ({o_k[t], o_db[t]} !== 9'h000) begin
            errors++;
            $display("FAIL frm%0d_filler t=%0d got=%h want=000",
              it, t, {o_k[t], o_db[t]});
          end
        end
      end
    end
  endtask

  task automatic test_max();
    int s, d;
    dmode = 0;
    for (int w = 0; w < 512; w++) write_word(w, 32'hFFFFFFFF);
    build_frame(512);
    clear_trace();
    txWords = 10'd512;
    txStart = 1'b1;
    tick();
    txStart = 1'b0;
    repeat (4104 + 8) tick();
    s = first_data(2);
    checks++;
    if (s < 2 || s > 3) begin
      errors++;
      $display("FAIL max_start got=%0d want=2..3", s);
    end else begin
      foreach (exp_q[m]) begin
        checks++;
        if ({o_k[s+2*m], o_db[s+2*m]} !== exp_q[m]) begin
          errors++;
          $display("FAIL max_byte%0d got=%h want=%h", m,
            {o_k[s+2*m], o_db[s+2*m]}, exp_q[m]);
        end
      end
      checks++;
      if ({o_db[s+4100], o_db[s+4102]} !== 16'h07FF) begin
        errors++;
        $display("FAIL max_cs got=%h want=07ff",
          {o_db[s+4100], o_db[s+4102]});
      end
      d = s + 4103;
      checks++;
      if ({o_bz[0], o_bz[d-1], o_bz[d], o_dn[d], o_dn[d+1]}
          !== 5'b11010) begin
        errors++;
        $display("FAIL max_done got=%b want=11010",
          {o_bz[0], o_bz[d-1], o_bz[d], o_dn[d], o_dn[d+1]});
      end
    end
  endtask

  task automatic test_reset_mid();
    int s, d, guard;
    dmode = 0;
    for (int w = 0; w < 64; w++) write_word(w, $urandom);
    build_frame(64);
    clear_trace();
    txWords = 10'd64;
    txStart = 1'b1;
    tick();
    txStart = 1'b0;
    repeat (3) tick();
    s = first_data(2);
    guard = 0;
    while (o_db.size() < s + 203 && guard < 400) begin
      tick();
      guard++;
    end
    checks++;
    if ({o_k[s+202], o_db[s+202]} !== exp_q[101]) begin
      errors++;
      $display("FAIL rmid_byte100 got=%h want=%h",
        {o_k[s+202], o_db[s+202]}, exp_q[101]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dbus, isK, dbSlot, txBusy, txDone, txErr} !== 13'h0) begin
      errors++;
      $display("FAIL rmid_reset got=%h want=0",
        {dbus, isK, dbSlot, txBusy, txDone, txErr});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    write_word(0, $urandom);
    build_frame(1);
    clear_trace();
    txWords = 10'd1;
    txStart = 1'b1;
    tick();
    txStart = 1'b0;
    repeat (20) tick();
    s = first_data(2);
    checks++;
    if (s < 2 || s > 3) begin
      errors++;
      $display("FAIL rmid_start got=%0d want=2..3", s);
    end else begin
      foreach (exp_q[m]) begin
        checks++;
        if ({o_k[s+2*m], o_db[s+2*m]} !== exp_q[m]) begin
          errors++;
          $display("FAIL rmid_byte%0d got=%h want=%h", m,
            {o_k[s+2*m], o_db[s+2*m]}, exp_q[m]);
        end
      end
      d = s + 15;
      checks++;
      if ({o_bz[0], o_bz[d-1], o_bz[d], o_dn[d], o_dn[d+1]}
          !== 5'b11010) begin
        errors++;
        $display("FAIL rmid_done got=%b want=11010",
          {o_bz[0], o_bz[d-1], o_bz[d], o_dn[d], o_dn[d+1]});
      end
    end
  endtask

  task automatic test_back_to_back();
    int s, d, k, errs;
    dmode = 0;
    write_word(0, $urandom);
    write_word(1, $urandom);
    build_frame(2);
    exp1_q = exp_q;
    clear_trace();
    txWords = 10'd2;
    txStart = 1'b1;
    for (int i = 0; i < 64; i++) begin
      // word 0 is already sent by index 14; frame 1 must not see it
      if (i == 14) begin
        wrEn = 1'b1;
        wrAddr = 9'd0;
        wrData = $urandom;
      end
      tick();
      if (i == 14) begin
        wrEn = 1'b0;
        sh[0] = wrData;
      end
    end
    txStart = 1'b0;
    build_frame(2);
    k = 0;
    for (int f = 0; f < 2; f++) begin
      s = first_data(k + 2);
      checks++;
      if (s < k + 2 || s > k + 3) begin
        errors++;
        $display("FAIL b2b%0d_start got=%0d want=2..3", f, s - k);
      end else begin
        for (int m = 0; m < exp_q.size(); m++) begin
          checks++;
          if ({o_k[s+2*m], o_db[s+2*m]} !==
              ((f == 0) ? exp1_q[m] : exp_q[m])) begin
            errors++;
            $display("FAIL b2b%0d_byte%0d got=%h want=%h", f, m,
              {o_k[s+2*m], o_db[s+2*m]},
              (f == 0) ? exp1_q[m] : exp_q[m]);
          end
        end
        d = s + 2 * exp_q.size() - 1;
        checks++;
        if ({o_bz[k], o_bz[d-1], o_bz[d], o_dn[d], o_dn[d+1]}
            !== 5'b11010) begin
          errors++;
          $display("FAIL b2b%0d_done got=%b want=11010", f,
            {o_bz[k], o_bz[d-1], o_bz[d], o_dn[d], o_dn[d+1]});
        end
        checks++;
        if ({o_bz[d+1], o_sl[d+1], o_k[d+1], o_db[d+1],
             o_k[d+3], o_db[d+3]} !== {3'b100, 8'h00, 1'b1, 8'h1C}) begin
          errors++;
          $display("FAIL b2b%0d_gap got=%b/%h k=%b db=%h want=100/00 1 1c",
            f, {o_bz[d+1], o_sl[d+1], o_k[d+1]}, o_db[d+1],
            o_k[d+3], o_db[d+3]);
        end
        k = d + 1;
      end
    end
    errs = 0;
    foreach (o_er[t]) if (o_er[t]) errs++;
    checks++;
    if (errs != 0) begin
      errors++;
      $display("FAIL b2b_txerr got=%0d want=0", errs);
    end
    repeat (40) tick();
  endtask

  initial begin
    rst = 1'b1;
    disBus = 8'h00;
    wrEn = 1'b0;
    wrAddr = 9'd0;
    wrData = 32'd0;
    txStart = 1'b0;
    txWords = 10'd0;
    for (int i = 0; i < 512; i++) sh[i] = 32'd0;
    test_reset();
    test_basic();
    test_illegal();
    test_frames_dbus();
    test_back_to_back();
    test_reset_mid();
    test_max();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/evr_dbus_encode.md
# evr_dbus_encode

Transmit-side encoder for the distributed-bus/data-buffer byte lane of the EVG/EVR link. It drives the upper (dbus) byte of the event stream with distributed-bus bytes interleaved with data-buffer frames. Each frame carries a K28.0 start, payload bytes, a K28.1 end and a 16-bit checksum. A 512×32 internal buffer is loaded by software, and a frame is sent on request.

## Interface
Parameters: none; the buffer depth is fixed at 512 words (2048 bytes).

Ports (clock and reset first):
- EventClock  in  1  event/link clock; the only clock.
- Reset  in  1  asynchronous, active-high reset.
- disBus  in  8  distributed-bus value to transmit.
- wrEn  in  1  buffer write strobe.
- wrAddr  in  9  buffer word address.
- wrData  in  32  buffer word. Byte order is big-endian: byte 4n is bits 31:24.
- txStart  in  1  frame request, level-sampled.
- txWords  in  10  frame length in 32-bit words; legal range 1..512.
- dbus  out  8  dbus byte lane, registered.
- isK  out  1  dbus byte is a K character, registered.
- dbSlot  out  1  1 = current dbus byte is a distributed-bus slot; 0 = data slot.
- txBusy  out  1  frame in progress.
- txDone  out  1  one-cycle pulse at frame end.
- txErr  out  1  one-cycle pulse when a request is rejected.

## Operation
- Slot phase: dbSlot toggles every cycle, without exception. The first output cycle after reset is a data slot (dbSlot=0).
- Distributed-bus slot: dbus=disBus registered (1-cycle latency), isK=0.
- Data slot, idle: dbus=0x00, isK=0.
- Buffer: inferred 512×32 RAM with synchronous read.
  - Writes are accepted at any time.
  - During a frame, a word is sent with whatever content it holds when it is read.
- Request handling, when txBusy=0 and txStart=1:
  - txWords in 1..512: latch N=4·txWords bytes, set txBusy, clear the 16-bit checksum.
  - txWords=0 or >512: pulse txErr and stay idle.
  - txStart while txBusy=1 is ignored, with no txErr.
- FSM states and data-slot contents:
  - IDLE: filler 0x00.
  - START: 0x1C with isK=1.
  - DATA: bytes 0..N-1 in ascending byte address, isK=0; sum += byte, modulo 2^16.
  - END: 0x3C with isK=1.
  - CSHI: (~sum)[15:8].
  - CSLO: (~sum)[7:0].
  - Then back to IDLE.
- Every state advances only on data slots. Distributed-bus slots interleave throughout the frame.
- The byte following each K character is always a distributed-bus slot.
- Frame on dbus: 1C, D, b0, D, b1, …, D, b(N-1), D, 3C, D, csHi, D, csLo, D. Here D = distributed-bus byte.
- Receiver-visible rules, which must hold for the decoder:
  - Reported size = N.
  - Complement of the 16-bit sum of the payload = {csHi, csLo}.
  - Payload bytes are never K.
- Reset mid-frame: all state returns to IDLE immediately and outputs go to their reset values. The truncated frame is never completed. The decoder resynchronises on the next 0x1C.

## Timing
- Reset values: dbus=0x00, isK=0, dbSlot=0, txBusy=0, txDone=0, txErr=0. Checksum and byte counter are 0; FSM=IDLE.
- txStart sampled at edge k, accepted: txBusy=1 from edge k.
  - 0x1C is driven at the first data slot at or after edge k+2 (i.e. k+2 or k+3, depending on phase).
  - Cycles k and k+1 are used for the RAM prefetch.
- Payload prefetch: RAM word i+1 is read while word i is being sent, so consecutive data slots never stall.
- Frame duration: 2·(N+4) cycles, from the 0x1C cycle through the D cycle after csLo.
- Frame end: txBusy=0 and txDone=1 on the edge that drives the D byte following csLo. txDone lasts exactly 1 cycle.
- Back-to-back: a txStart held high is re-accepted on the cycle after txBusy falls. The next 0x1C follows the rule above, so the minimum gap is one filler data slot.
- txErr: asserted at edge k+1 for 1 cycle.

## Test plan
- Basic frame: disBus=0xA5, buffer word 0=0x01020304, txWords=1, txStart pulse -> dbus sequence 1C(K), A5, 01, A5, 02, A5, 03, A5, 04, A5, 3C(K), A5, FF, A5, F5, A5. Then txDone one cycle and txBusy=0.
- Max frame: 512 words of 0xFFFFFFFF -> 2048 payload bytes; checksum bytes 0x07, 0xFF; frame is 4104 cycles long; no K inside the payload.
- Illegal length: txWords=0, then txWords=513 -> txErr pulses once each, txBusy stays 0, dbus data slots stay 0x00.
- Distributed bus: disBus ramps 0x00..0xFF every cycle, idle and during a frame. Each D slot equals disBus from the previous cycle, and dbSlot toggles continuously.
- Reset mid-frame: assert Reset during byte 100 of a 256-byte frame -> all outputs at reset values within the reset cycle. A new 1-word frame afterwards is bit-exact with a correct checksum.
- Busy/contention: txStart re-asserted mid-frame is ignored. A held txStart produces back-to-back frames separated by exactly one filler data slot when the phase allows. Writes to an already-sent word mid-frame do not alter that frame's checksum.
